// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle nop/add/sub/lui plus an iterative shift-add multiply.
// Optional signed/unsigned overflow flag output enabled by defining ALU_EXEC_OVF_EN.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef ALU_EXEC_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int unsigned HALF = WIDTH / 2;
`ifdef ALU_EXEC_OVF_EN
    localparam int unsigned ACC_W = 2 * WIDTH;
`else
    localparam int unsigned ACC_W = WIDTH;
`endif
    localparam logic [4:0]       OP_ADD   = 5'd1;
    localparam logic [4:0]       OP_SUB   = 5'd2;
    localparam logic [4:0]       OP_MUL   = 5'd3;
    localparam logic [4:0]       OP_LUI   = 5'd4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [ACC_W-1:0]   acc_next;

    assign in_ready  = (state_q == IDLE) & (~out_valid_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = (state_q == MUL);

    assign sum      = a + b;
    assign diff     = a - b;
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef ALU_EXEC_OVF_EN
    logic ovf_q, ovf_d;
    logic add_ovf;
    logic sub_ovf;

    assign ovf     = ovf_q;
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
`endif

    // Next-state, datapath and output-register logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q & ~out_ready;
`ifdef ALU_EXEC_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d  = MUL;
                        cnt_d    = '0;
                        mcand_d  = ACC_W'(a);
                        mplier_d = b;
                        acc_d    = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        case (op)
                            OP_ADD:  result_d = sum;
                            OP_SUB:  result_d = diff;
                            OP_LUI:  result_d = {b[HALF-1:0], {HALF{1'b0}}};
                            default: result_d = '0;
                        endcase
`ifdef ALU_EXEC_OVF_EN
                        ovf_d = ((op == OP_ADD) & add_ovf) | ((op == OP_SUB) & sub_ovf);
`endif
                    end
                end
            end
            MUL: begin
                // One shift-add step per cycle; the pipeline is stalled via in_ready
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    result_d    = acc_next[WIDTH-1:0];
                    out_valid_d = 1'b1;
`ifdef ALU_EXEC_OVF_EN
                    ovf_d       = |acc_next[ACC_W-1:WIDTH];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef ALU_EXEC_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_EXEC_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus randomized traffic
// scored against a transaction-level model (result, ovf, first-valid cycle).
module tb_alu_exec_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;
`ifdef ALU_EXEC_OVF_EN
    logic         ovf;
`endif

    alu_exec_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef ALU_EXEC_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        int           due;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   checked  = 1'b0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference behaviour from the operation definitions, in plain arithmetic
    function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t          e;
        logic [2*W-1:0] p;
        longint        sx, sy, s, lim;
        e.res = '0;
        e.ovf = 1'b0;
        e.due = 0;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        lim = longint'(1) << (W - 1);
        case (o)
            5'd1: begin
                e.res = W'(x + y);
                s     = sx + sy;
                e.ovf = (s >= lim) || (s < -lim);
            end
            5'd2: begin
                e.res = W'(x - y);
                s     = sx - sy;
                e.ovf = (s >= lim) || (s < -lim);
            end
            5'd3: begin
                p     = (2*W)'(x) * (2*W)'(y);
                e.res = p[W-1:0];
                e.ovf = (p >> W) != '0;
            end
            5'd4: e.res = W'(y << (W / 2));
            default: ;
        endcase
        return e;
    endfunction

    // Output scoreboard: each result checked once on first appearance, popped on consumption
    always @(negedge clk) begin
        if (rst_n) begin
            if (!checked) begin
                if (q.size() == 0) begin
                    check_eq("idle_valid", 64'(out_valid), 64'(0));
                end else if (out_valid) begin
                    check_eq("result", 64'(result), 64'(q[0].res));
                    check_eq("latency", 64'(cyc), 64'(q[0].due));
`ifdef ALU_EXEC_OVF_EN
                    check_eq("ovf", 64'(ovf), 64'(q[0].ovf));
`endif
                    checked = 1'b1;
                end
            end
            if (out_valid && out_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                checked = 1'b0;
            end
        end
    end

    task automatic rand_out_ready();
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            rand_out_ready();
        end
    endtask

    task automatic send(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int   bound = 300;
        exp_t e;
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        #1;
        while (!in_ready && bound > 0) begin
            @(posedge clk);
            #2;
            rand_out_ready();
            bound--;
            #1;
        end
        if (!in_ready) begin
            check_eq("send_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #2;
        e     = model(o, x, y);
        e.due = cyc + ((o == 5'd3) ? int'(W) : 0);
        q.push_back(e);
        in_valid = 1'b0;
        rand_out_ready();
    endtask

    task automatic drain();
        int bound = 200;
        out_ready = 1'b1;
        while (q.size() != 0 && bound > 0) begin
            @(posedge clk);
            #2;
            bound--;
        end
        check_eq("drain", 64'(q.size()), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [4:0] ro;
        logic [W-1:0] ra, rb;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        op        = 5'd1;
        a         = 32'd3;
        b         = 32'd4;
        out_ready = 1'b1;

        // Reset held two cycles with a live request
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_result", 64'(result), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));

        // Back-to-back single-cycle ops
        c0 = cyc;
        send(5'd1, 32'hFFFF_FFFF, 32'd1);
        send(5'd2, 32'd5, 32'd7);
        send(5'd4, 32'hDEAD_1234, 32'h0000_1234);
        send(5'd0, 32'h1111_1111, 32'h2222_2222);
        send(5'd7, 32'h1234_5678, 32'h9ABC_DEF0);
        check_eq("b2b_cycles", 64'(cyc - c0), 64'(5));
        idle(2);

        // Multiply with stall and ignored inputs
        send(5'd3, 32'd12345, 32'd6789);
        for (int i = 0; i < int'(W); i++) begin
            check_eq("mul_busy", 64'(busy), 64'(1));
            check_eq("mul_in_ready", 64'(in_ready), 64'(0));
            in_valid = 1'b1;
            op = 5'd1;
            a  = $urandom;
            b  = $urandom;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        check_eq("mul_done_busy", 64'(busy), 64'(0));
        check_eq("mul_done_valid", 64'(out_valid), 64'(1));
        check_eq("mul_product", 64'(result), 64'(83810205));
        send(5'd3, 32'hFFFF_FFFF, 32'd2);
        drain();

        // Backpressure hold then release with a new request
        out_ready = 1'b0;
        send(5'd1, 32'd3, 32'd4);
        repeat (5) begin
            check_eq("hold_in_ready", 64'(in_ready), 64'(0));
            check_eq("hold_valid", 64'(out_valid), 64'(1));
            check_eq("hold_result", 64'(result), 64'(7));
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        send(5'd2, 32'd10, 32'd4);
        drain();

        // Reset during multiply
        send(5'd3, $urandom, $urandom);
        repeat (10) begin
            @(posedge clk);
            #2;
        end
        rst_n = 1'b0;
        q.delete();
        checked = 1'b0;
        @(posedge clk);
        #2;
        check_eq("midrst_busy", 64'(busy), 64'(0));
        check_eq("midrst_valid", 64'(out_valid), 64'(0));
        rst_n = 1'b1;
        send(5'd1, 32'd1, 32'd1);
        drain();

        // Overflow corners
        send(5'd1, 32'h7FFF_FFFF, 32'd1);
        send(5'd2, 32'h8000_0000, 32'd1);
        send(5'd1, 32'd1, 32'd1);
        drain();

        // Randomized traffic with random output backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0: ro = 5'd0;
                1, 6: ro = 5'd1;
                2, 7: ro = 5'd2;
                3, 8: ro = 5'd3;
                4, 9: ro = 5'd4;
                default: ro = 5'($urandom_range(5, 31));
            endcase
            case ($urandom_range(0, 5))
                0: ra = 32'hFFFF_FFFF;
                1: ra = 32'h8000_0000;
                2: ra = 32'h7FFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'hFFFF_FFFF;
                1: rb = 32'd1;
                2: rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            send(ro, ra, rb);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        drain();
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
